dilate_win_ctrl: RTL and testbench

DILATE_WIN_CTRL -- requirements
Module: dilate_win_ctrl

---
 rtl/dilate_win_ctrl.sv | 153 +++++++++++++++
 tb/tb_dilate_win_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dilate_win_ctrl.sv
// dilate_win_ctrl: raster-to-3x3-window row feeder for a dilation kernel.
// Buffers two image rows and, per output column, presents the column samples
// of rows c-1 / c / c+1 around output centre row c, with zero pad at the
// top and bottom borders.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              frame start request (sampled in IDLE only)
//   pix_valid/pix_data raster-order input pixel stream
//   pix_ready          pixel accepted this cycle when high with pix_valid
//   win_valid          row_top/row_mid/row_bot valid (window valid_in)
//   row_top/mid/bot    column samples for the current output column
//   busy               controller is not IDLE
//   frame_done         one-cycle pulse after the last window column
module dilate_win_ctrl #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned PIC_WIDTH  = 320,
    parameter int unsigned PIC_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] pix_data,
    output logic             pix_ready,
    output logic             win_valid,
    output logic [WIDTH-1:0] row_top,
    output logic [WIDTH-1:0] row_mid,
    output logic [WIDTH-1:0] row_bot,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int unsigned RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] lb0 [PIC_WIDTH];
    logic [WIDTH-1:0] lb1 [PIC_WIDTH];

    logic accept;
    logic col_wrap;

    assign accept   = pix_valid & pix_ready;
    assign col_wrap = (col == COL_LAST);

    // Line buffers: lb0 holds the previous row, lb1 the one before it.
    // Not reset; FILL overwrites them and the border pads hide stale data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
        end
    end

    // Frame control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            pix_ready  <= 1'b0;
            win_valid  <= 1'b0;
            row_top    <= '0;
            row_mid    <= '0;
            row_bot    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col       <= '0;
                        row       <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (col_wrap) begin
                            col   <= '0;
                            row   <= row + RW'(1);
                            state <= RUN;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        win_valid <= 1'b1;
                        row_bot   <= pix_data;
                        row_mid   <= lb0[col];
                        // centre row 0 has no row above it
                        row_top   <= (row == ROW_ONE) ? '0 : lb1[col];
                        if (col_wrap) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row       <= '0;
                                pix_ready <= 1'b0;
                                state     <= FLUSH;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // last centre row: lb0 = row H-1, lb1 = row H-2, bottom pad
                    win_valid <= 1'b1;
                    row_top   <= lb1[col];
                    row_mid   <= lb0[col];
                    row_bot   <= '0;
                    if (col_wrap) begin
                        col   <= '0;
                        state <= DONE;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dilate_win_ctrl.sv
// Self-checking bench for dilate_win_ctrl (WIDTH=8, 4x3 frame, pixel = 16*row+col).
module tb_dilate_win_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int WD = 8;

    typedef struct packed {
        logic [WD-1:0] t;
        logic [WD-1:0] m;
        logic [WD-1:0] b;
    } win_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [WD-1:0] pix_data = '0;
    logic          pix_ready;
    logic          win_valid;
    logic [WD-1:0] row_top, row_mid, row_bot;
    logic          busy;
    logic          frame_done;

    dilate_win_ctrl #(.WIDTH(WD), .PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .win_valid(win_valid),
        .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] pv(input int r, input int c);
        return WD'(16 * r + c);
    endfunction

    // Expected windows of one frame, in emission order, from the border rules.
    win_t exp_q[$];
    task automatic build_q;
        win_t w;
        exp_q.delete();
        for (int c = 0; c < H; c++) begin
            for (int x = 0; x < W; x++) begin
                w.t = (c == 0)     ? '0 : pv(c - 1, x);
                w.m = pv(c, x);
                w.b = (c == H - 1) ? '0 : pv(c + 1, x);
                exp_q.push_back(w);
            end
        end
    endtask

    // Model state: 0 idle, 1 accepting, 2 flushing, 3 done
    int            mph = 0;
    int            n_acc = 0;
    int            rem = 0;
    logic          exp_wv = 1'b0, exp_fd = 1'b0, exp_ready = 1'b0, exp_busy = 1'b0;
    win_t          exp_win = '0;
    int            fd_count = 0;
    int            wcount = 0;
    logic [23:0]   cap [12];

    task automatic emit;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL model_queue got=empty expected=window at %0t", $time);
        end else begin
            exp_win = exp_q.pop_front();
        end
    endtask

    // Compare DUT to model every cycle, then advance the model one cycle.
    always @(negedge clk) begin
        chk("win_valid", 32'(win_valid), 32'(exp_wv));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("rows", 32'({row_top, row_mid, row_bot}), 32'(exp_win));
        if (win_valid) begin
            if (fd_count == 0 && wcount < 12) cap[wcount] = {row_top, row_mid, row_bot};
            wcount++;
        end
        if (frame_done) begin
            chk("frame_win_count", 32'(wcount), 32'(W * H));
            wcount = 0;
        end
        if (exp_fd) fd_count++;

        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (!rst_n) begin
            mph = 0; n_acc = 0; rem = 0; wcount = 0;
            exp_win = '0; exp_ready = 1'b0; exp_busy = 1'b0;
        end else begin
            case (mph)
                0: if (start) begin
                    mph = 1; n_acc = 0; build_q();
                end
                1: if (pix_valid) begin
                    if (n_acc >= W) begin emit(); exp_wv = 1'b1; end
                    n_acc++;
                    if (n_acc == W * H) begin mph = 2; rem = W; end
                end
                2: begin
                    emit(); exp_wv = 1'b1; rem--;
                    if (rem == 0) mph = 3;
                end
                default: begin
                    exp_fd = 1'b1; mph = 0;
                end
            endcase
            exp_ready = (mph == 1);
            exp_busy  = (mph != 0);
        end
    end

    int sent = 0;

    // mode 0: valid always high; 1: toggling valid + start pulse in RUN;
    // 2: reset at row 1 col 2.
    task automatic run_frame(input int mode, input bit keep_start, input bit do_start);
        int  base;
        int  cyc;
        bit  acc;
        bit  quit;
        base = fd_count;
        cyc  = 0;
        quit = 0;
        if (do_start) start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        sent = 0;
        while (fd_count == base && cyc < 200 && !quit) begin
            pix_valid = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            pix_data  = pv(sent / W, sent % W);
            if (mode == 1) start = (sent == 6);
            if (mode == 2 && sent == W + 2) begin
                rst_n = 1'b0;
                pix_valid = 1'b0;
            end
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (!rst_n) begin
                chk("rst_win_valid", 32'(win_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_pix_ready", 32'(pix_ready), 32'd0);
                chk("rst_rows", 32'({row_top, row_mid, row_bot}), 32'd0);
                rst_n = 1'b1;
                quit = 1;
            end
            cyc++;
        end
        pix_valid = 1'b0;
        if (mode == 1) start = 1'b0;
        if (cyc >= 200) begin
            failures++;
            $display("FAIL frame_timeout got=%0d cycles expected=frame_done", cyc);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_win_valid", 32'(win_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 0, 1);
        chk("cap0", 32'(cap[0]), 32'h000010);
        chk("cap3", 32'(cap[3]), 32'h000313);
        chk("cap4", 32'(cap[4]), 32'h001020);
        chk("cap7", 32'(cap[7]), 32'h031323);
        chk("cap8", 32'(cap[8]), 32'h102000);
        chk("cap11", 32'(cap[11]), 32'h132300);

        repeat (2) @(posedge clk); #1;
        run_frame(1, 0, 1);
        repeat (2) @(posedge clk); #1;
        run_frame(0, 1, 1);
        run_frame(0, 0, 0);
        repeat (2) @(posedge clk); #1;
        run_frame(2, 0, 1);
        repeat (2) @(posedge clk); #1;
        run_frame(0, 0, 1);
        repeat (3) @(posedge clk); #1;
        chk("frames_done_total", 32'(fd_count), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
